// File: rtl/ex_forward_scoreboard_pkg.sv
// Shared definitions for the EX forwarding scoreboard: opcode encodings and
// the bit layout of one in-flight producer entry.
package ex_forward_scoreboard_pkg;

  typedef enum logic [6:0] {
    OP_IMME_ARITHMETIC   = 7'b0010011,
    OP_ARITHMETIC        = 7'b0110011,
    OP_CONDITIONAL_JMP   = 7'b1100011,
    OP_UNCONDITIONAL_JMP = 7'b1101111,
    OP_MEMORY_LOAD       = 7'b0000011,
    OP_MEMORY_STORE      = 7'b0100011
  } opcode_t;

  // Entry layout, LSB first: flags, then rd, then result data.
  localparam int F_VALID    = 0;
  localparam int F_REGWRITE = 1;
  localparam int F_LOAD     = 2;
  localparam int F_READY    = 3;
  localparam int F_RD       = 4;

  function automatic int f_data(input int reg_addr_w);
    return F_RD + reg_addr_w;
  endfunction

  function automatic int entry_w(input int xlen, input int reg_addr_w);
    return f_data(reg_addr_w) + xlen;
  endfunction

endpackage

// File: rtl/ex_forward_scoreboard_if.sv
// EX-stage operand/forwarding bundle between the pipeline and the scoreboard.
interface ex_forward_scoreboard_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int CNT_W      = 16
);
  logic                          ex_valid;
  logic                          ex_kill;
  logic [REG_ADDR_W-1:0]         ex_rd;
  logic                          ex_regwrite;
  logic                          ex_is_load;
  logic [XLEN-1:0]               ex_alu_result;
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs;
  logic [NUM_SRC-1:0]            ex_rs_used;
  logic                          ld_data_valid;
  logic [XLEN-1:0]               ld_data;
  logic [NUM_SRC*XLEN-1:0]       fwd_data;
  logic [NUM_SRC-1:0]            fwd_en;
  logic                          ex_stall;
  logic [CNT_W-1:0]              stall_count;

  modport master (
    output ex_valid, ex_kill, ex_rd, ex_regwrite, ex_is_load, ex_alu_result,
           ex_rs, ex_rs_used, ld_data_valid, ld_data,
    input  fwd_data, fwd_en, ex_stall, stall_count
  );

  modport slave (
    input  ex_valid, ex_kill, ex_rd, ex_regwrite, ex_is_load, ex_alu_result,
           ex_rs, ex_rs_used, ld_data_valid, ld_data,
    output fwd_data, fwd_en, ex_stall, stall_count
  );
endinterface

// File: rtl/ex_forward_scoreboard_fwd_lookup.sv
// Priority search of the in-flight producer slots for one EX source operand;
// the youngest (lowest-index) matching producer decides forward vs hazard.
module fwd_lookup
  import ex_forward_scoreboard_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int DEPTH        = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int LD_BYPASS    = 0
) (
  input  logic [DEPTH*entry_w(XLEN, REG_ADDR_W)-1:0] slots,
  input  logic [REG_ADDR_W-1:0]                      rs,
  input  logic                                       rs_used,
  input  logic                                       ld_data_valid,
  input  logic [XLEN-1:0]                            ld_data,
  output logic                                       en,
  output logic [XLEN-1:0]                            data,
  output logic                                       hazard
);
  localparam int EW     = entry_w(XLEN, REG_ADDR_W);
  localparam int F_DATA = f_data(REG_ADDR_W);
  localparam int L      = LOAD_LATENCY - 1;

  logic [DEPTH-1:0] match;
  logic             found;
  logic             win_ready;
  logic             win_load;
  logic             win_at_l;
  logic [XLEN-1:0]  win_data;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = slots[gi*EW + F_VALID] && slots[gi*EW + F_REGWRITE] &&
                         (slots[gi*EW + F_RD +: REG_ADDR_W] == rs) &&
                         (rs != '0) && rs_used;
    end
  endgenerate

  // Walk oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    found     = 1'b0;
    win_ready = 1'b0;
    win_load  = 1'b0;
    win_at_l  = 1'b0;
    win_data  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        found     = 1'b1;
        win_ready = slots[i*EW + F_READY];
        win_load  = slots[i*EW + F_LOAD];
        win_at_l  = (i == L);
        win_data  = slots[i*EW + F_DATA +: XLEN];
      end
    end
  end

  always_comb begin
    en     = 1'b0;
    data   = '0;
    hazard = 1'b0;
    if (found) begin
      if (win_ready) begin
        en   = 1'b1;
        data = win_data;
      end else if ((LD_BYPASS != 0) && win_at_l && win_load && ld_data_valid) begin
        en   = 1'b1;
        data = ld_data;
      end else begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_forward_scoreboard.sv
// EX-stage forwarding scoreboard: shift buffer of in-flight producers with
// per-source forwarding, load-use stall and in-buffer load data capture.
module ex_forward_scoreboard
  import ex_forward_scoreboard_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int DEPTH        = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int LD_BYPASS    = 0,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  ex_forward_scoreboard_if.slave  bus
);
  localparam int EW     = entry_w(XLEN, REG_ADDR_W);
  localparam int F_DATA = f_data(REG_ADDR_W);
  localparam int L      = LOAD_LATENCY - 1;

  logic [EW-1:0]           slot_reg  [DEPTH];
  logic [EW-1:0]           slot_next [DEPTH];
  logic [DEPTH*EW-1:0]     slots_flat;
  logic [EW-1:0]           new_entry;
  logic [EW-1:0]           cap_entry;
  logic                    capture;
  logic                    issue;
  logic                    stall;
  logic [NUM_SRC-1:0]      hazard;
  logic [NUM_SRC-1:0]      fwd_en_int;
  logic [NUM_SRC*XLEN-1:0] fwd_data_int;
  logic [CNT_W-1:0]        stall_count_reg;

  assign issue   = bus.ex_valid && !bus.ex_kill && !stall;
  assign capture = slot_reg[L][F_VALID] && slot_reg[L][F_LOAD] && bus.ld_data_valid;

  always_comb begin
    new_entry = '0;
    if (issue) begin
      new_entry[F_VALID]              = 1'b1;
      new_entry[F_REGWRITE]           = bus.ex_regwrite;
      new_entry[F_LOAD]               = bus.ex_is_load;
      new_entry[F_READY]              = !bus.ex_is_load;
      new_entry[F_RD +: REG_ADDR_W]   = bus.ex_rd;
      new_entry[F_DATA +: XLEN]       = bus.ex_alu_result;
    end
  end

  // The load leaving slot L picks up memory data as it moves to L+1.
  always_comb begin
    cap_entry                  = slot_reg[L];
    cap_entry[F_READY]         = 1'b1;
    cap_entry[F_DATA +: XLEN]  = bus.ld_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slots_flat[gi*EW +: EW] = slot_reg[gi];
      if (gi == 0) begin : g_head
        assign slot_next[gi] = new_entry;
      end else if (gi == L + 1) begin : g_cap
        assign slot_next[gi] = capture ? cap_entry : slot_reg[gi-1];
      end else begin : g_shift
        assign slot_next[gi] = slot_reg[gi-1];
      end
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_lookup #(
        .XLEN         (XLEN),
        .REG_ADDR_W   (REG_ADDR_W),
        .DEPTH        (DEPTH),
        .LOAD_LATENCY (LOAD_LATENCY),
        .LD_BYPASS    (LD_BYPASS)
      ) u_lookup (
        .slots         (slots_flat),
        .rs            (bus.ex_rs[gi*REG_ADDR_W +: REG_ADDR_W]),
        .rs_used       (bus.ex_rs_used[gi]),
        .ld_data_valid (bus.ld_data_valid),
        .ld_data       (bus.ld_data),
        .en            (fwd_en_int[gi]),
        .data          (fwd_data_int[gi*XLEN +: XLEN]),
        .hazard        (hazard[gi])
      );
    end
  endgenerate

  assign stall = (|hazard) && bus.ex_valid && !bus.ex_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg[i] <= '0;
      end
      stall_count_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg[i] <= slot_next[i];
      end
      if (stall && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
    end
  end

  assign bus.fwd_en      = fwd_en_int;
  assign bus.fwd_data    = fwd_data_int;
  assign bus.ex_stall    = stall;
  assign bus.stall_count = stall_count_reg;

endmodule

// File: doc/ex_forward_scoreboard.md
Name: ex_forward_scoreboard

Overview:
Parametrised successor to the EX-stage forwarding/stall logic. It holds an in-flight shift buffer of DEPTH producer entries: slot 0 is EX/MEM, slot 1 is MEM/WB, and further slots cover deeper pipelines. Each entry stores rd, regwrite, load flag, ready bit and result data. The block forwards per-source operands to the instruction in EX, stalls EX on not-yet-ready producers, and captures load data itself at a configurable latency.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register address width
NUM_SRC, 2, source operands checked per EX instruction
DEPTH, 2, tracked producer slots after EX (≥2)
LOAD_LATENCY, 1, slot index+1 at which load data arrives; 1 ≤ LOAD_LATENCY < DEPTH
LD_BYPASS, 0, 1 = forward ld_data combinationally in its arrival cycle
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX holds a real instruction
ex_kill  in  1  EX instruction squashed; enters as bubble
ex_rd  in  REG_ADDR_W  EX destination
ex_regwrite  in  1  EX writes rd
ex_is_load  in  1  EX result comes from memory
ex_alu_result  in  XLEN  EX ALU result
ex_rs  in  NUM_SRC*REG_ADDR_W  EX sources, flattened, source j at [j*REG_ADDR_W +: REG_ADDR_W]
ex_rs_used  in  NUM_SRC  source j actually read
ld_data_valid  in  1  load data for slot LOAD_LATENCY-1 present
ld_data  in  XLEN  load data
fwd_data  out  NUM_SRC*XLEN  forwarded operand per source
fwd_en  out  NUM_SRC  use fwd_data instead of regfile
ex_stall  out  1  hold EX, insert bubble
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset, synchronous, active-high:
  - all slots invalid, data 0
  - stall_count 0
  - fwd_en 0, fwd_data 0, ex_stall 0 (no valid slots means no matches)
- Shift on every clock:
  - slot i moves to slot i+1; slot DEPTH-1 retires (the regfile write occurs in WB).
  - Slot 0 loads {valid=1, rd, regwrite, is_load, ready=!ex_is_load, data=ex_alu_result} iff ex_valid && !ex_kill && !ex_stall.
  - Otherwise slot 0 loads a bubble (valid=0).
- Load capture:
  - If slot L=LOAD_LATENCY-1 is valid with is_load, and ld_data_valid=1, then slot L+1 receives data=ld_data, ready=1 on the shift.
  - ld_data_valid while slot L is not a valid load is ignored.
  - A load reaching slot L without ld_data_valid moves on with ready still 0. EX keeps stalling on it; no deadlock check is performed.
- Lookup, combinational, per source j:
  - Candidates are valid && regwrite && rd==rs[j] && rd!=0 && ex_rs_used[j]=1.
  - The youngest candidate (lowest slot) wins; older matches are ignored.
  - Winner ready: fwd_en[j]=1, fwd_data[j]=winner data.
  - Winner is slot L, not ready, ld_data_valid=1 and LD_BYPASS=1: fwd_en[j]=1, fwd_data[j]=ld_data.
  - Winner not ready in any other case: source hazard.
  - No winner: fwd_en[j]=0, fwd_data[j]=0.
- ex_stall = OR of source hazards, qualified by ex_valid && !ex_kill.
- Source hazards force fwd_en 0 for that source.
- rs==0 never forwards and never stalls.
- stall_count increments each cycle ex_stall=1 and saturates at all-ones.
- Default params (DEPTH=2, LOAD_LATENCY=1, LD_BYPASS=0) give:
  - EX/MEM ALU forward
  - MEM/WB forward of ALU or load data
  - one-cycle load-use stall
- Reset mid-operation: all in-flight entries are discarded next cycle, with no forwarding from them afterwards.

Decomposition:
- Shared header pipeline_defs.vh holds:
  - the opcode constants (OP_IMME_ARITHMETIC, OP_ARITHMETIC, OP_CONDITIONAL_JMP, OP_UNCONDITIONAL_JMP, OP_MEMORY_LOAD, OP_MEMORY_STORE)
  - slot-field offsets for the packed entry vector
- One sub-module, fwd_lookup: priority search over DEPTH slots for one source, producing {en, data, hazard}. It is instantiated NUM_SRC times via generate.

Test Plan:
- ALU→ALU back-to-back: write x5=0x11 in EX, next EX reads rs1=x5 -> fwd_en[0]=1, fwd_data=0x11, ex_stall=0.
- Distance 2: x6=0x22 then an independent instruction, then a reader of x6 on rs2 -> forwarded from slot 1, fwd_en[1]=1, data 0x22.
- Load-use: load x7 issued, ld_data_valid with 0xDEAD next cycle; reader of x7 follows immediately -> ex_stall=1 for exactly 1 cycle, stall_count=1, then fwd_data=0xDEAD. With LD_BYPASS=1 -> no stall, data 0xDEAD same cycle.
- Priority/x0: x8=1 then x8=2 back-to-back, reader of x8 -> data 2. Writer x0=0x55 then reader of x0 -> fwd_en=0, no stall.
- ex_kill/ex_rs_used: killed writer of x9 followed by reader of x9 -> fwd_en=0. Pending load to x10 with ex_rs_used[1]=0 on rs2=x10 -> no stall.
- Reset mid-flight: rst for 1 cycle with x11 in slot 0, reader of x11 the next cycle -> fwd_en=0, stall_count=0.
